// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters with registered sync, visible-area and start strobes.
// Outputs are decoded from next-state counters so sync/display_on never skew from hc/vc.
module vga_sync_gen #(
  parameter int   HVIS      = 640,
  parameter int   HFP       = 16,
  parameter int   HSW       = 96,
  parameter int   HBP       = 48,
  parameter int   VVIS      = 480,
  parameter int   VFP       = 10,
  parameter int   VSW       = 2,
  parameter int   VBP       = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start
);

  localparam int HTOTAL = HVIS + HFP + HSW + HBP;
  localparam int VTOTAL = VVIS + VFP + VSW + VBP;

  if (HTOTAL > 2048 || VTOTAL > 2048) begin : g_bad_totals
    $error("vga_sync_gen: HTOTAL and VTOTAL must not exceed 2048");
  end

  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);

  // Thresholds carried at 12 bits so a boundary of exactly 2048 stays representable.
  localparam logic [11:0] H_VIS_END = 12'(HVIS);
  localparam logic [11:0] V_VIS_END = 12'(VVIS);
  localparam logic [11:0] HS_BEG    = 12'(HVIS + HFP);
  localparam logic [11:0] HS_END    = 12'(HVIS + HFP + HSW);
  localparam logic [11:0] VS_BEG    = 12'(VVIS + VFP);
  localparam logic [11:0] VS_END    = 12'(VVIS + VFP + VSW);

  logic [10:0] hc_nxt;
  logic [10:0] vc_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic        hs_act_nxt;
  logic        vs_act_nxt;
  logic        disp_nxt;

  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    h_wrap = pix_ce && (hc == H_LAST);
    v_wrap = h_wrap && (vc == V_LAST);
    if (pix_ce) begin
      if (h_wrap) begin
        hc_nxt = 11'd0;
        vc_nxt = v_wrap ? 11'd0 : vc + 11'd1;
      end else begin
        hc_nxt = hc + 11'd1;
      end
    end
    hs_act_nxt = ({1'b0, hc_nxt} >= HS_BEG) && ({1'b0, hc_nxt} < HS_END);
    vs_act_nxt = ({1'b0, vc_nxt} >= VS_BEG) && ({1'b0, vc_nxt} < VS_END);
    disp_nxt   = ({1'b0, hc_nxt} < H_VIS_END) && ({1'b0, vc_nxt} < V_VIS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= 11'd0;
      vc          <= 11'd0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= hs_act_nxt ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act_nxt ? VSYNC_POL : ~VSYNC_POL;
      display_on  <= disp_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule
